// File: rtl/ps2_mouse_sequencer_if.sv
// ps2_mouse_sequencer_if: command/receive bus between the sequencer and ps2_transmitter
interface ps2_mouse_sequencer_if;
    logic [7:0] tx_data;
    logic       tx_enable;
    logic       tx_busy;
    logic       tx_complete;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_error;
    modport master (output tx_data, tx_enable, input tx_busy, tx_complete, rx_data, rx_valid, rx_error);
    modport slave (input tx_data, tx_enable, output tx_busy, tx_complete, rx_data, rx_valid, rx_error);
endinterface

// File: rtl/ps2_mouse_sequencer.sv
// ps2_mouse_sequencer: PS/2 mouse init handshake with timeouts/retries, then 3-byte packet decode
module ps2_mouse_sequencer #(
    parameter int TIMEOUT_CYCLES = 50_000_000,
    parameter int BYTE_TIMEOUT   = 200_000,
    parameter int MAX_RETRY      = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    ps2_mouse_sequencer_if.master bus,
    output logic                  init_done,
    output logic                  init_fail,
    output logic [1:0]            retry_cnt,
    output logic                  pkt_valid,
    output logic [2:0]            btn,
    output logic [8:0]            dx,
    output logic [8:0]            dy,
    output logic                  x_ovf,
    output logic                  y_ovf
);
    typedef enum logic [3:0] {
        IDLE, SEND_RST, WAIT_ACK1, WAIT_BAT, WAIT_ID, SEND_EN, WAIT_ACK2, B1, B2, B3, FAIL
    } state_t;
    state_t      state, state_n;
    logic [31:0] cnt, cnt_n;
    logic [6:0]  hdr, hdr_n;
    logic [7:0]  b2, b2_n, tx_data_n;
    logic        tx_enable_n, init_done_n, init_fail_n, pkt_valid_n, x_ovf_n, y_ovf_n;
    logic [1:0]  retry_cnt_n;
    logic [2:0]  btn_n;
    logic [8:0]  dx_n, dy_n;
    logic        in_send, in_wait, accept, done, hit, timeout, gap_out, fail, enter;
    assign in_send = state == SEND_RST || state == SEND_EN;
    assign in_wait = state inside {WAIT_ACK1, WAIT_BAT, WAIT_ID, WAIT_ACK2};
    assign accept  = bus.rx_valid && !bus.rx_error;
    assign done    = in_send && bus.tx_complete && !bus.tx_busy;
    assign hit     = accept && (((state == WAIT_ACK1 || state == WAIT_ACK2) && bus.rx_data == 8'hFA)
                             || (state == WAIT_BAT && bus.rx_data == 8'hAA)
                             || (state == WAIT_ID && bus.rx_data == 8'h00));
    assign timeout = (in_send || in_wait) && cnt == 32'(TIMEOUT_CYCLES - 1);
    assign gap_out = (state == B2 || state == B3) && cnt == 32'(BYTE_TIMEOUT - 1);
    // an expected byte or a finished command beats a coinciding timeout; rx_error always fails
    assign fail    = (in_wait && bus.rx_error) || (state == WAIT_BAT && accept && bus.rx_data == 8'hFC)
                  || (timeout && !hit && !done);
    assign enter   = fail || state_n != state;
    // state and all registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            cnt           <= '0;
            hdr           <= '0;
            b2            <= '0;
            bus.tx_data   <= '0;
            bus.tx_enable <= 1'b0;
            init_done     <= 1'b0;
            init_fail     <= 1'b0;
            retry_cnt     <= '0;
            pkt_valid     <= 1'b0;
            btn           <= '0;
            dx            <= '0;
            dy            <= '0;
            x_ovf         <= 1'b0;
            y_ovf         <= 1'b0;
        end else begin
            state         <= state_n;
            cnt           <= cnt_n;
            hdr           <= hdr_n;
            b2            <= b2_n;
            bus.tx_data   <= tx_data_n;
            bus.tx_enable <= tx_enable_n;
            init_done     <= init_done_n;
            init_fail     <= init_fail_n;
            retry_cnt     <= retry_cnt_n;
            pkt_valid     <= pkt_valid_n;
            btn           <= btn_n;
            dx            <= dx_n;
            dy            <= dy_n;
            x_ovf         <= x_ovf_n;
            y_ovf         <= y_ovf_n;
        end
    end
    // next state: handshake progression, packet byte tracking, failure/retry override
    always_comb begin
        state_n = state;
        case (state)
            IDLE:      state_n = SEND_RST;
            SEND_RST:  if (done) state_n = WAIT_ACK1;
            WAIT_ACK1: if (hit) state_n = WAIT_BAT;
            WAIT_BAT:  if (hit) state_n = WAIT_ID;
            WAIT_ID:   if (hit) state_n = SEND_EN;
            SEND_EN:   if (done) state_n = WAIT_ACK2;
            WAIT_ACK2: if (hit) state_n = B1;
            B1:        if (accept && bus.rx_data[3]) state_n = B2;
            B2:        state_n = bus.rx_error ? B1 : accept ? B3 : gap_out ? B1 : B2;
            B3:        if (bus.rx_error || accept || gap_out) state_n = B1;
            default:   state_n = state;
        endcase
        if (fail) state_n = retry_cnt >= 2'(MAX_RETRY) ? FAIL : SEND_RST;
    end
    // next values of the registered outputs; header keeps only the bits used downstream
    always_comb begin
        cnt_n       = (enter || !(in_send || in_wait || state == B2 || state == B3)) ? '0 : cnt + 32'd1;
        tx_enable_n = in_send && !enter;
        tx_data_n   = state == SEND_RST ? 8'hFF : state == SEND_EN ? 8'hF4 : bus.tx_data;
        retry_cnt_n = (fail && state_n == SEND_RST) ? retry_cnt + 2'd1 : retry_cnt;
        init_fail_n = init_fail || (fail && state_n == FAIL);
        init_done_n = fail ? 1'b0 : (state == WAIT_ACK2 && hit) || init_done;
        pkt_valid_n = state == B3 && accept;
        hdr_n       = (state == B1 && accept && bus.rx_data[3]) ? {bus.rx_data[7:4], bus.rx_data[2:0]} : hdr;
        b2_n        = (state == B2 && accept) ? bus.rx_data : b2;
        btn_n       = pkt_valid_n ? hdr[2:0] : btn;
        dx_n        = pkt_valid_n ? {hdr[3], b2} : dx;
        dy_n        = pkt_valid_n ? {hdr[4], bus.rx_data} : dy;
        x_ovf_n     = pkt_valid_n ? hdr[5] : x_ovf;
        y_ovf_n     = pkt_valid_n ? hdr[6] : y_ovf;
    end
endmodule

// File: tb/tb_ps2_mouse_sequencer.sv
// tb_ps2_mouse_sequencer: scoreboard bench with a transmitter model and a packet reference model
module tb_ps2_mouse_sequencer;
    localparam int TO  = 100;
    localparam int BTO = 50;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       init_done, init_fail, pkt_valid, x_ovf, y_ovf;
    logic [1:0] retry_cnt;
    logic [2:0] btn;
    logic [8:0] dx, dy;
    typedef struct {
        int btn;
        int dx;
        int dy;
        int xo;
        int yo;
    } pkt_t;
    pkt_t       exp_q[$];
    logic [7:0] pend[$];
    logic [7:0] cmd_q[$];
    int         vectors = 0;
    int         errs = 0;
    int         cmds_done = 0;

    always #5 clk = ~clk;

    ps2_mouse_sequencer_if bus();

    ps2_mouse_sequencer #(.TIMEOUT_CYCLES(TO), .BYTE_TIMEOUT(BTO), .MAX_RETRY(3)) dut (
        .clk(clk), .rst(rst), .bus(bus),
        .init_done(init_done), .init_fail(init_fail), .retry_cnt(retry_cnt),
        .pkt_valid(pkt_valid), .btn(btn), .dx(dx), .dy(dy), .x_ovf(x_ovf), .y_ovf(y_ovf)
    );

    task automatic check(input string name, input int act, input int req);
        vectors++;
        if (act != req) begin
            errs++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    // reference: byte 1 must have bit 3 set, three bytes form a packet with signed 9-bit deltas
    function automatic void model_byte(input logic [7:0] b);
        pkt_t p;
        if (pend.size() == 0 && !b[3]) return;
        pend.push_back(b);
        if (pend.size() == 3) begin
            p.btn = int'(pend[0]) % 8;
            p.dx  = pend[0][4] ? int'(pend[1]) - 256 : int'(pend[1]);
            p.dy  = pend[0][5] ? int'(pend[2]) - 256 : int'(pend[2]);
            p.xo  = int'(pend[0][6]);
            p.yo  = int'(pend[0][7]);
            exp_q.push_back(p);
            pend.delete();
        end
    endfunction

    task automatic send(input logic [7:0] b, input bit err = 1'b0, input bit mdl = 1'b1);
        @(negedge clk);
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        bus.rx_error = err;
        if (mdl) begin
            if (err) pend.delete();
            else model_byte(b);
        end
        @(negedge clk);
        bus.rx_valid = 1'b0;
        bus.rx_error = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
        if (n >= BTO) pend.delete();
    endtask

    task automatic wait_cmds(input int n, input int limit);
        int k = 0;
        while (cmds_done < n && k < limit) begin
            @(negedge clk);
            k++;
        end
        check("cmd_wait", int'(cmds_done >= n), 1);
        repeat (2) @(negedge clk);
    endtask

    task automatic check_zero(input string tag);
        check({tag, ".init_done"}, int'(init_done), 0);
        check({tag, ".init_fail"}, int'(init_fail), 0);
        check({tag, ".retry_cnt"}, int'(retry_cnt), 0);
        check({tag, ".pkt_valid"}, int'(pkt_valid), 0);
        check({tag, ".btn"}, int'(btn), 0);
        check({tag, ".dx"}, int'(dx), 0);
        check({tag, ".dy"}, int'(dy), 0);
        check({tag, ".ovf"}, int'({x_ovf, y_ovf}), 0);
        check({tag, ".tx_enable"}, int'(bus.tx_enable), 0);
        check({tag, ".tx_data"}, int'(bus.tx_data), 0);
    endtask

    task automatic do_init(input int exp_retry);
        int base;
        base = cmds_done;
        cmd_q.push_back(8'hFF);
        wait_cmds(base + 1, 200);
        send(8'hFA, 1'b0, 1'b0);
        send(8'hAA, 1'b0, 1'b0);
        send(8'h00, 1'b0, 1'b0);
        check("init_done_early", int'(init_done), 0);
        cmd_q.push_back(8'hF4);
        wait_cmds(base + 2, 200);
        send(8'hFA, 1'b0, 1'b0);
        check("init_done", int'(init_done), 1);
        check("init_retry_cnt", int'(retry_cnt), exp_retry);
    endtask

    task automatic drain();
        int k = 0;
        while (exp_q.size() != 0 && k < 20) begin
            @(negedge clk);
            k++;
        end
        check("pkt_drain", exp_q.size(), 0);
    endtask

    // transmitter model: checks each requested command, then busy for 3 cycles and a complete strobe
    initial begin
        bus.tx_busy     = 1'b0;
        bus.tx_complete = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.tx_enable) begin
                if (cmd_q.size() == 0) begin
                    vectors++;
                    errs++;
                    $display("FAIL unexpected_cmd: got %0h, expected none", bus.tx_data);
                end else check("tx_data", int'(bus.tx_data), int'(cmd_q.pop_front()));
                bus.tx_busy = 1'b1;
                repeat (3) @(negedge clk);
                bus.tx_busy     = 1'b0;
                bus.tx_complete = 1'b1;
                cmds_done++;
                @(negedge clk);
                bus.tx_complete = 1'b0;
            end
        end
    end

    // packet monitor: every pkt_valid pops one expected packet
    always @(negedge clk) begin
        pkt_t p;
        if (pkt_valid) begin
            if (exp_q.size() == 0) begin
                vectors++;
                errs++;
                $display("FAIL unexpected_pkt: got btn=%0d dx=%0d dy=%0d, expected none", btn, $signed(dx), $signed(dy));
            end else begin
                p = exp_q.pop_front();
                check("pkt_btn", int'(btn), p.btn);
                check("pkt_dx", int'($signed(dx)), p.dx);
                check("pkt_dy", int'($signed(dy)), p.dy);
                check("pkt_x_ovf", int'(x_ovf), p.xo);
                check("pkt_y_ovf", int'(y_ovf), p.yo);
            end
        end
    end

    initial begin
        int base;
        int k;
        bit seen;
        bus.rx_data  = 8'h00;
        bus.rx_valid = 1'b0;
        bus.rx_error = 1'b0;
        repeat (3) @(negedge clk);
        check_zero("reset");
        rst = 1'b0;
        do_init(0);
        // directed decode and resync
        send(8'h18); send(8'h05); send(8'hF0);
        send(8'h09); send(8'h00); send(8'h00);
        send(8'h00);
        send(8'h08); send(8'h01); send(8'h02);
        drain();
        // rx_error during byte 3, and coinciding with a valid byte 2
        send(8'h08); send(8'h11); send(8'h22, 1'b1);
        send(8'h0B); send(8'h33, 1'b1);
        send(8'h09); send(8'h03); send(8'h04);
        // short gap kept, long gap drops the partial packet
        send(8'hC8); idle(BTO - 10); send(8'h7F); send(8'h80);
        send(8'h08); idle(BTO + 5); send(8'h28); send(8'h10); send(8'h20);
        drain();
        // randomized stream with errors and long gaps
        for (int i = 0; i < 150; i++) begin
            k = int'($urandom_range(0, 19));
            send(8'($urandom), k == 0);
            idle(k == 1 ? BTO + 5 : int'($urandom_range(0, 3)));
        end
        idle(BTO + 5);
        drain();
        // byte 1 wait has no timeout
        idle(300);
        send(8'h08); send(8'h01); send(8'h02);
        drain();
        // reset mid-packet, then self-test error forces one retry
        send(8'h28);
        @(negedge clk);
        rst = 1'b1;
        pend.delete();
        @(negedge clk);
        check_zero("rst_mid");
        rst  = 1'b0;
        base = cmds_done;
        cmd_q.push_back(8'hFF);
        wait_cmds(base + 1, 200);
        send(8'hFA, 1'b0, 1'b0);
        send(8'hFC, 1'b0, 1'b0);
        check("fc_retry_cnt", int'(retry_cnt), 1);
        do_init(1);
        send(8'h3F); send(8'hFF); send(8'h01);
        drain();
        // silence after reset command: three retries then failure
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst  = 1'b0;
        base = cmds_done;
        repeat (4) cmd_q.push_back(8'hFF);
        wait_cmds(base + 2, 400);
        check("to_retry_cnt", int'(retry_cnt), 1);
        wait_cmds(base + 4, 600);
        k = 0;
        while (!init_fail && k < 300) begin
            @(negedge clk);
            k++;
        end
        check("init_fail", int'(init_fail), 1);
        check("fail_retry_cnt", int'(retry_cnt), 3);
        check("fail_init_done", int'(init_done), 0);
        seen = 1'b0;
        repeat (150) begin
            @(negedge clk);
            seen |= bus.tx_enable;
        end
        check("fail_tx_enable", int'(seen), 0);
        check("fail_sticky", int'(init_fail), 1);
        check("cmd_q_empty", cmd_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule

// File: doc/ps2_mouse_sequencer.md
# ps2_mouse_sequencer

Sequencing controller that drives the `ps2_transmitter` command/receive port for a PS/2 mouse. It runs the power-on handshake: reset, ACK, self-test, ID, enable reporting, ACK. Each step has a timeout and the whole handshake has bounded retries. It then assembles the 3-byte stream packets into signed X/Y deltas and button state. It sits between `ps2_transmitter` and the application logic (cursor/LED/note position), replacing ad-hoc init FSMs in top-level modules.

## Interface
- `TIMEOUT_CYCLES`, 50_000_000: per-step response timeout during init, in clk cycles.
- `BYTE_TIMEOUT`, 200_000: max gap between bytes 2/3 of a stream packet, in clk cycles.
- `MAX_RETRY`, 3: number of handshake restarts before declaring failure.

Ports:
- `clk`  in  1  system clock; one clock domain.
- `rst`  in  1  reset; synchronous and active-high.
- `tx_data`  out  8  command byte to `ps2_transmitter.parallel_data_out`.
- `tx_enable`  out  1  command request to `parallel_data_enable`.
- `tx_busy`  in  1  `ps2_transmitter.busy`.
- `tx_complete`  in  1  `data_out_complete`.
- `rx_data`  in  8  `parallel_data_in`.
- `rx_valid`  in  1  one-cycle strobe, rx_data valid.
- `rx_error`  in  1  `data_in_error` (parity/framing).
- `init_done`  out  1  handshake complete, streaming active.
- `init_fail`  out  1  sticky; retries exhausted.
- `retry_cnt`  out  2  restarts performed so far.
- `pkt_valid`  out  1  one-cycle strobe, new packet on outputs.
- `btn`  out  3  {middle, right, left}, 1 = pressed.
- `dx`, `dy`  out  9 each  two's-complement deltas {sign, byte}.
- `x_ovf`, `y_ovf`  out  1 each  overflow flags from byte 1.

## Operation
- All outputs are registered. Reset values are 0 for every output. `tx_data` resets to 0x00. State resets to IDLE, and the timeout counter and retry_cnt reset to 0.
- States and transitions:
  - IDLE: go to SEND_RST on the next cycle.
  - SEND_RST: `tx_data`=0xFF, `tx_enable`=1. When `tx_complete && !tx_busy`, go to WAIT_ACK1.
  - WAIT_ACK1: rx 0xFA goes to WAIT_BAT.
  - WAIT_BAT: rx 0xAA goes to WAIT_ID. rx 0xFC (self-test error) is a failure.
  - WAIT_ID: rx 0x00 goes to SEND_EN.
  - SEND_EN: `tx_data`=0xF4, `tx_enable`=1. On complete, go to WAIT_ACK2.
  - WAIT_ACK2: rx 0xFA goes to B1 and sets `init_done`.
  - B1, B2, B3: packet bytes 1–3.
  - FAIL: terminal until `rst`.
- Init-phase rules:
  - In the WAIT_* states, any other `rx_valid` byte is ignored.
  - The timeout counter clears on every state entry and counts in SEND_*/WAIT_* states.
  - Failure conditions: counter reaches TIMEOUT_CYCLES-1, `rx_error` in a WAIT_* state, or 0xFC in WAIT_BAT.
  - On failure with `retry_cnt` < MAX_RETRY: increment `retry_cnt`, drop `tx_enable`, go to SEND_RST.
  - On failure with `retry_cnt` == MAX_RETRY: go to FAIL, set `init_fail`, `tx_enable`=0.
  - `tx_enable` is low in every non-SEND state.
- Streaming rules:
  - B1: `rx_valid` with `rx_data[3]`=1 latches byte 1 and goes to B2. With bit3=0, the byte is discarded (resync) and the state stays in B1. B1 has no timeout.
  - B2 and B3: latch bytes 2 and 3.
  - `rx_error`, or a gap reaching BYTE_TIMEOUT-1 cycles in B2/B3, discards the partial packet and returns to B1 with no `pkt_valid`.
  - On the byte-3 accept, go to B1 and update the outputs:
    - `btn`=b1[2:0]
    - `dx`={b1[4],b2}, `dy`={b1[5],b3}
    - `x_ovf`=b1[6], `y_ovf`=b1[7]
    - `pkt_valid`=1 for exactly one cycle.
  - Packet outputs hold their last values between packets.
- `init_done` stays 1 through streaming. It clears only on `rst` or a retry (it is never set again after FAIL).

## Timing
- `tx_enable`/`tx_data` are asserted starting the cycle after SEND_* entry. They are held stable until the cycle after `tx_complete && !tx_busy` is sampled, then low.
- A WAIT_* state accepts a byte in the same cycle `rx_valid` is high. The next state is effective on the following edge.
- `init_done` rises 1 cycle after the 0xFA `rx_valid` in WAIT_ACK2.
- `pkt_valid` and the updated packet outputs appear 1 cycle after the byte-3 `rx_valid`. A new byte-1 accept may occur in the same cycle `pkt_valid` is high.
- If a timeout and `rx_valid` with an expected byte coincide, the byte wins and no retry is taken.
- If `rx_error` and `rx_valid` coincide, the error wins.
- `rst` mid-operation returns to IDLE next edge with `tx_enable`=0 immediately (registered), and clears `init_fail` and `retry_cnt`.

## Test plan
- Clean init: model completes 0xFF, returns FA, AA, 00, completes 0xF4, returns FA → `init_done`=1; `retry_cnt`=0. `tx_data` sequence is 0xFF then 0xF4.
- Packet decode: bytes 0x18, 0x05, 0xF0 → one `pkt_valid`; `dx`=0x105 (−251); `dy`=0x0F0 (+240); `btn`=000. Then 0x09, 0x00, 0x00 → `btn`=001, `dx`=`dy`=0.
- Resync: byte 0x00 (bit3=0) → discarded; then 0x08, 0x01, 0x02 → single packet, `dx`=1, `dy`=2.
- Timeout/retry: no ACK after the reset with TIMEOUT_CYCLES=100 → `retry_cnt`=1, 0xFF resent; silence continues → after 3 retries `init_fail`=1 and `tx_enable` stays 0.
- Errors: `rx_error` during B3 → no `pkt_valid`, returns to B1. 0xFC in WAIT_BAT → retry. A byte-2 gap of BYTE_TIMEOUT cycles → partial packet dropped.
- Reset mid-stream: `rst` during B2 → all outputs 0 next cycle, and the handshake restarts with 0xFF.
